// File: rtl/module_clk_enables_if.sv
// Control and strobe bundle for the clock-enable generator: per-channel enables,
// divide-ratio loads and shared resync in; tick/sq strobes and locked out.
interface module_clk_enables_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 16
);
    logic [N_CH-1:0]  en;
    logic [N_CH-1:0]  div_load;
    logic [CNT_W-1:0] div_value;
    logic             resync;
    logic [N_CH-1:0]  tick;
    logic [N_CH-1:0]  sq;
    logic             locked;

    modport master (
        output en, div_load, div_value, resync,
        input  tick, sq, locked
    );

    modport slave (
        input  en, div_load, div_value, resync,
        output tick, sq, locked
    );
endinterface

// File: rtl/module_clk_enables.sv
// Multi-channel clock-enable generator: per-channel tick strobes and /2D square waves on clk.
// All outputs registered (1 cycle after the deciding edge); free-running, no backpressure.
module module_clk_enables #(
    parameter int N_CH        = 4,
    parameter int CNT_W       = 16,
    parameter int DIV_DEFAULT = 10,
    parameter int LOCK_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    module_clk_enables_if.slave bus
);
    localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {
        ST_WAIT = 1'b0,
        ST_RUN  = 1'b1
    } lock_state_t;

    lock_state_t       r_state;
    lock_state_t       w_state_nxt;
    logic [LOCK_W-1:0] r_lock_cnt;
    logic [LOCK_W-1:0] w_lock_cnt_nxt;
    logic              w_locked;

    logic [CNT_W-1:0]  r_cnt      [N_CH];
    logic [CNT_W-1:0]  r_div      [N_CH];
    logic [CNT_W-1:0]  w_cnt_nxt  [N_CH];
    logic [CNT_W-1:0]  w_div_nxt  [N_CH];
    logic [N_CH-1:0]   r_tick;
    logic [N_CH-1:0]   r_sq;
    logic [N_CH-1:0]   w_tick_nxt;
    logic [N_CH-1:0]   w_sq_nxt;
    logic [CNT_W-1:0]  w_div_clamp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_WAIT;
            r_lock_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
        end
    end

    // The counter saturates at LOCK_CYCLES because it only advances while waiting.
    always_comb begin
        w_state_nxt    = r_state;
        w_lock_cnt_nxt = r_lock_cnt;
        case (r_state)
            ST_WAIT: begin
                w_lock_cnt_nxt = r_lock_cnt + LOCK_W'(1);
                if (r_lock_cnt == LOCK_W'(LOCK_CYCLES - 1)) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt    = ST_WAIT;
                w_lock_cnt_nxt = '0;
            end
        endcase
    end

    assign w_locked    = (r_state == ST_RUN);
    assign w_div_clamp = (bus.div_value == '0) ? CNT_ONE : bus.div_value;

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            w_cnt_nxt[i]  = r_cnt[i];
            w_div_nxt[i]  = r_div[i];
            w_tick_nxt[i] = 1'b0;
            w_sq_nxt[i]   = r_sq[i];

            if (bus.div_load[i]) begin
                w_div_nxt[i] = w_div_clamp;
            end

            // Priority: not locked > resync > load > enable.
            if (!w_locked || bus.resync) begin
                w_cnt_nxt[i] = '0;
                w_sq_nxt[i]  = 1'b0;
            end else if (bus.div_load[i]) begin
                w_cnt_nxt[i] = '0;
            end else if (bus.en[i]) begin
                if (r_cnt[i] == r_div[i] - CNT_ONE) begin
                    w_cnt_nxt[i]  = '0;
                    w_tick_nxt[i] = 1'b1;
                    w_sq_nxt[i]   = ~r_sq[i];
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                r_cnt[i] <= '0;
                r_div[i] <= CNT_W'(DIV_DEFAULT);
            end
            r_tick <= '0;
            r_sq   <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
                r_div[i] <= w_div_nxt[i];
            end
            r_tick <= w_tick_nxt;
            r_sq   <= w_sq_nxt;
        end
    end

    assign bus.tick   = r_tick;
    assign bus.sq     = r_sq;
    assign bus.locked = w_locked;
endmodule

// File: tb/tb_module_clk_enables.sv
module tb_module_clk_enables;
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    module_clk_enables_if #(.N_CH(4), .CNT_W(16)) bus ();

    module_clk_enables #(
        .N_CH(4), .CNT_W(16), .DIV_DEFAULT(10), .LOCK_CYCLES(16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_tick;
        logic [31:0] exp_sq;
        int          first;

        rst_n         = 1'b0;
        bus.en        = 4'hF;
        bus.div_load  = 4'h0;
        bus.div_value = 16'h0;
        bus.resync    = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_locked", 32'(bus.locked), 0);
        check("rst_tick", 32'(bus.tick), 0);
        check("rst_sq", 32'(bus.sq), 0);

        // Lock sequence: locked rises after the 16th edge
        rst_n = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            step();
            check("lock_locked", 32'(bus.locked), (e == 16) ? 1 : 0);
            check("lock_tick", 32'(bus.tick), 0);
            check("lock_sq", 32'(bus.sq), 0);
        end

        // Default D=10 on all channels, then load D=3 on channel 1 at j=16 (sq[1]=1 then)
        for (int j = 1; j <= 40; j++) begin
            bus.div_load  = (j == 16) ? 4'b0010 : 4'b0000;
            bus.div_value = 16'd3;
            step();
            exp_tick = 0;
            exp_sq   = 0;
            for (int c = 0; c < 4; c++) begin
                if (c == 1 && j >= 16) begin
                    exp_tick[c] = (j > 16) && ((j - 16) % 3 == 0);
                    exp_sq[c]   = 1'b1 ^ 1'(((j - 16) / 3) % 2);
                end else begin
                    exp_tick[c] = (j % 10 == 0);
                    exp_sq[c]   = 1'((j / 10) % 2);
                end
            end
            check("run_tick", 32'(bus.tick), exp_tick);
            check("run_sq", 32'(bus.sq), exp_sq);
        end
        bus.div_load = 4'h0;

        // Load 0 clamps to 1: tick every cycle, sq toggles every cycle
        bus.div_load  = 4'hF;
        bus.div_value = 16'd0;
        step();
        bus.div_load  = 4'h0;
        check("load0_tick", 32'(bus.tick), 0);
        check("load0_sq_hold", 32'(bus.sq), 32'h2);
        for (int k = 1; k <= 4; k++) begin
            step();
            check("d1_tick", 32'(bus.tick), 32'hF);
            check("d1_sq", 32'(bus.sq), (k % 2 == 1) ? 32'hD : 32'h2);
        end

        bus.div_load  = 4'hF;
        bus.div_value = 16'd1;
        step();
        bus.div_load  = 4'h0;
        check("load1_tick", 32'(bus.tick), 0);
        for (int k = 1; k <= 2; k++) begin
            step();
            check("load1_run_tick", 32'(bus.tick), 32'hF);
            check("load1_run_sq", 32'(bus.sq), (k % 2 == 1) ? 32'hD : 32'h2);
        end

        // D=65535: first tick exactly 65535 edges after the load
        bus.div_load  = 4'hF;
        bus.div_value = 16'hFFFF;
        step();
        bus.div_load  = 4'h0;
        check("dmax_load_tick", 32'(bus.tick), 0);
        first = 0;
        for (int k = 1; k <= 65600 && first == 0; k++) begin
            step();
            if (bus.tick != 4'h0) first = k;
        end
        check("dmax_first_tick_edge", 32'(first), 32'd65535);
        check("dmax_tick", 32'(bus.tick), 32'hF);
        check("dmax_sq", 32'(bus.sq), 32'hD);
        step();
        check("dmax_after_tick", 32'(bus.tick), 0);

        // D=5 with en[2] dropped for edges 8..14
        bus.div_load  = 4'hF;
        bus.div_value = 16'd5;
        step();
        bus.div_load  = 4'h0;
        for (int k = 1; k <= 22; k++) begin
            bus.en = (k >= 8 && k <= 14) ? 4'b1011 : 4'b1111;
            step();
            exp_tick = 0;
            for (int c = 0; c < 4; c++) begin
                if (c == 2) exp_tick[c] = (k == 5) || (k == 17) || (k == 22);
                else        exp_tick[c] = (k % 5 == 0);
            end
            check("gate_tick", 32'(bus.tick), exp_tick);
        end
        check("gate_sq", 32'(bus.sq), 32'h9);

        // resync together with div_load[0]=4
        bus.resync    = 1'b1;
        bus.div_load  = 4'b0001;
        bus.div_value = 16'd4;
        step();
        bus.resync    = 1'b0;
        bus.div_load  = 4'h0;
        check("resync_tick", 32'(bus.tick), 0);
        check("resync_sq", 32'(bus.sq), 0);
        for (int k = 1; k <= 5; k++) begin
            step();
            exp_tick = (k == 4) ? 32'h1 : ((k == 5) ? 32'hE : 32'h0);
            check("resync_run_tick", 32'(bus.tick), exp_tick);
        end
        check("resync_run_sq", 32'(bus.sq), 32'hF);

        // Async reset mid-period clears outputs without an edge
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_locked", 32'(bus.locked), 0);
        check("arst_tick", 32'(bus.tick), 0);
        check("arst_sq", 32'(bus.sq), 0);
        step();
        step();
        rst_n = 1'b1;
        for (int e = 1; e <= 26; e++) begin
            step();
            check("relock_locked", 32'(bus.locked), (e >= 16) ? 1 : 0);
            check("relock_tick", 32'(bus.tick), (e == 26) ? 32'hF : 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
